ahb_master_engine: RTL and testbench
====================================

// Module: ahb_master_engine
// PURPOSE
//  Bus-side counterpart of the client arbitration mux: consumes the muxed request (mode, pixNum, wdata,
//  size, startAddr_sel) and runs single non-pipelined AHB-Lite NONSEQ transfers.
//  Returns rdata plus a one-cycle data_feedback pulse per completed beat, which the mux steers to the
//  active client (RC4, ED or SI). Sits between the client mux and the AHB-Lite fabric.
// PARAMETERS
//  READ_BASE   32'h0000_0000  byte base address when startAddr_sel=0 (source image / RC4 buffer)
//  WRITE_BASE  32'h0010_0000  byte base address when startAddr_sel=1 (ED output buffer)
//  MAX_PIX     20'd307200     pixel count per buffer; used only by the bounds check
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  mode           in   2   00 idle, 01 read, 10 write, 11 reserved (treated as idle)
//  pixNum         in   20  pixel index of the requested beat
//  wdata          in   32  write data; halfword writes use wdata[15:0]
//  size           in   2   01 halfword, 10 word (00/11 treated as word)
//  startAddr_sel  in   1   base select: 0 READ_BASE, 1 WRITE_BASE
//  rdata          out  32  read data of last completed read beat
//  data_feedback  out  1   1-cycle pulse: beat completed OK
//  bus_err        out  1   sticky error flag
//  HADDR          out  32  AHB address
//  HTRANS         out  2   AHB transfer type: IDLE=00 or NONSEQ=10 only
//  HWRITE         out  1   AHB write enable
//  HSIZE          out  3   AHB size: 001 or 010
//  HWDATA         out  32  AHB write data
//  HRDATA         in   32  AHB read data
//  HREADY         in   1   AHB ready
//  HRESP          in   1   AHB response: 0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0,
//    rdata=0, data_feedback=0, bus_err=0.
//  Address: HADDR = base + (pixNum << (size==01 ? 1 : 2)); add in 32 bits, wrap mod 2^32.
//  FSM
//   IDLE: HTRANS=00. On mode in {01,10}, latch mode/pixNum/wdata/size/sel -> ADDR.
//     In IDLE, mode=00 clears bus_err.
//   ADDR: HTRANS=10 with HADDR/HWRITE/HSIZE from the latched request. On HREADY -> DATA.
//     With HREADY low, hold all outputs.
//   DATA: HTRANS=00; HWDATA=latched wdata (halfword: {wdata[15:0],wdata[15:0]}).
//     HREADY=1 & HRESP=0: for a read, rdata=HRDATA, or for a halfword read the lane selected by
//       HADDR[1], zero-extended. Pulse data_feedback next cycle -> IDLE.
//     HRESP=1 & HREADY=0: first error cycle -> ERR.
//   ERR: on HREADY -> set bus_err, no data_feedback, rdata unchanged -> IDLE.
//  Latency: request sampled in IDLE to data_feedback = 3 cycles at zero wait states (IDLE->ADDR->DATA->pulse).
//    Back-to-back beats occur every 3 cycles.
//  Request inputs are ignored outside IDLE; a mode change mid-beat does not affect the beat in flight.
//  The client updates pixNum on the data_feedback edge; IDLE samples the new request the next cycle.
//  mode=11: no transfer, stays IDLE.
// CONFIGURATION
//  AHB_BOUNDS_CHECK_EN defined: in IDLE, a request with pixNum >= MAX_PIX issues no bus transfer,
//    sets bus_err and pulses no feedback.
//  AHB_BOUNDS_CHECK_EN undefined: no check; every request is issued and the address wraps.
// STRUCTURE
//  ahb_pkg: typedef enum {IDLE, ADDR, DATA, ERR} state_t; HTRANS_IDLE/HTRANS_NONSEQ;
//    HSIZE_HALF/HSIZE_WORD; MODE_IDLE/MODE_READ/MODE_WRITE.
//  Sub-module ahb_addr_gen: combinational base select + shift + add. FSM and registers stay in the top level.
// TESTING
//  1 Word read: mode=01, pixNum=5, sel=0, HRDATA=32'hDEADBEEF, zero wait
//    -> HADDR=32'h14, HSIZE=010, rdata=DEADBEEF, dfb pulse at cycle 3.
//  2 Halfword write: mode=10, size=01, sel=1, pixNum=3, wdata=16'hA5C3
//    -> HADDR=32'h0010_0006, HWRITE=1, HWDATA=A5C3A5C3, one dfb pulse.
//  3 Wait states: HREADY low 2 cycles in ADDR and 3 in DATA
//    -> outputs held, dfb arrives at cycle 8, exactly once.
//  4 Error: HRESP=1 two cycles (HREADY 0 then 1) -> bus_err=1, no dfb;
//    then mode=00 for one cycle -> bus_err=0.
//  5 Reset mid-DATA: rst pulse -> HTRANS=00 and all outputs at reset values in the same cycle;
//    no dfb afterwards.
//  6 Bounds (macro on): pixNum=MAX_PIX -> HTRANS stays 00, bus_err=1.
//    Macro off -> transfer issued to the wrapped address.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared FSM state type and AHB-Lite / client-mode encodings for the master engine
package ahb_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [1:0] MODE_IDLE     = 2'b00;
    localparam logic [1:0] MODE_READ     = 2'b01;
    localparam logic [1:0] MODE_WRITE    = 2'b10;
endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: byte address = selected base + pixel index scaled by beat size (wraps mod 2^32)
module ahb_addr_gen #(
    parameter logic [31:0] READ_BASE  = 32'h0000_0000,
    parameter logic [31:0] WRITE_BASE = 32'h0010_0000
) (
    input  logic        sel,
    input  logic [19:0] pix_num,
    input  logic        half,
    output logic [31:0] addr
);
    assign addr = (sel ? WRITE_BASE : READ_BASE) + (half ? {11'b0, pix_num, 1'b0} : {10'b0, pix_num, 2'b0});
endmodule

// File: rtl/ahb_master_engine.sv
// ahb_master_engine: single non-pipelined AHB-Lite NONSEQ beats for the client mux; optional AHB_BOUNDS_CHECK_EN rejects pixNum >= MAX_PIX
module ahb_master_engine
    import ahb_pkg::*;
#(
    parameter logic [31:0] READ_BASE  = 32'h0000_0000,
    parameter logic [31:0] WRITE_BASE = 32'h0010_0000,
    parameter logic [19:0] MAX_PIX    = 20'd307200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [19:0] pixNum,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        startAddr_sel,
    output logic [31:0] rdata,
    output logic        data_feedback,
    output logic        bus_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
`ifdef AHB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    state_t state, next;
    logic [31:0] addr;
    logic half, req, oob, accept, done_ok;
    assign half    = size == 2'b01;
    assign req     = mode == MODE_READ || mode == MODE_WRITE;
    assign oob     = BOUNDS_EN && pixNum >= MAX_PIX;
    assign accept  = state == IDLE && req && !oob;
    assign done_ok = state == DATA && HREADY && !HRESP;
    assign HTRANS  = state == ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    ahb_addr_gen #(.READ_BASE(READ_BASE), .WRITE_BASE(WRITE_BASE)) u_addr_gen (
        .sel(startAddr_sel),
        .pix_num(pixNum),
        .half(half),
        .addr(addr)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // next-state: one beat walks IDLE->ADDR->DATA, error responses detour through ERR
    always_comb begin
        next = state;
        case (state)
            IDLE: next = accept ? ADDR : IDLE;
            ADDR: next = HREADY ? DATA : ADDR;
            DATA: next = HREADY ? IDLE : (HRESP ? ERR : DATA);
            ERR:  next = HREADY ? IDLE : ERR;
            default: next = IDLE;
        endcase
    end
    // request latch, read capture, feedback pulse and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HADDR         <= 32'h0;
            HWRITE        <= 1'b0;
            HSIZE         <= HSIZE_WORD;
            HWDATA        <= 32'h0;
            rdata         <= 32'h0;
            data_feedback <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            data_feedback <= done_ok;
            if (accept) begin
                HADDR  <= addr;
                HWRITE <= mode == MODE_WRITE;
                HSIZE  <= half ? HSIZE_HALF : HSIZE_WORD;
                HWDATA <= half ? {wdata[15:0], wdata[15:0]} : wdata;
            end
            if (done_ok && !HWRITE)
                rdata <= HSIZE == HSIZE_HALF ? {16'h0, HADDR[1] ? HRDATA[31:16] : HRDATA[15:0]} : HRDATA;
            if (state == IDLE && mode == MODE_IDLE)
                bus_err <= 1'b0;
            else if ((state == ERR && HREADY) || (state == DATA && HREADY && HRESP) || (state == IDLE && req && oob))
                bus_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_master_engine.sv
// tb_ahb_master_engine: directed checks of the AHB master engine (build with AHB_BOUNDS_CHECK_EN to cover the bounds check)
module tb_ahb_master_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [19:0] pixNum = 20'd0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  size = 2'b10;
    logic        startAddr_sel = 1'b0;
    logic [31:0] rdata, HADDR, HWDATA;
    logic        data_feedback, bus_err, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    int checks = 0;
    int errors = 0;

    ahb_master_engine dut (
        .clk(clk), .rst(rst), .mode(mode), .pixNum(pixNum), .wdata(wdata), .size(size),
        .startAddr_sel(startAddr_sel), .rdata(rdata), .data_feedback(data_feedback), .bus_err(bus_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] m, input logic [19:0] p, input logic [1:0] s,
                           input logic sel, input logic [31:0] wd);
        mode = m; pixNum = p; size = s; startAddr_sel = sel; wdata = wd;
    endtask

    initial begin
        tick();
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hsize", 32'(HSIZE), 32'h2);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_dfb", 32'(data_feedback), 32'h0);
        check("rst_err", 32'(bus_err), 32'h0);
        rst = 1'b0;
        tick();
        // 1: word read, zero wait states
        request(2'b01, 20'd5, 2'b10, 1'b0, 32'h0);
        HRDATA = 32'hDEADBEEF;
        tick();
        request(2'b00, 20'd0, 2'b10, 1'b0, 32'h0);
        check("t1_htrans_addr", 32'(HTRANS), 32'h2);
        check("t1_haddr", HADDR, 32'h14);
        check("t1_hsize", 32'(HSIZE), 32'h2);
        check("t1_hwrite", 32'(HWRITE), 32'h0);
        tick();
        check("t1_htrans_data", 32'(HTRANS), 32'h0);
        check("t1_dfb_early", 32'(data_feedback), 32'h0);
        tick();
        check("t1_dfb", 32'(data_feedback), 32'h1);
        check("t1_rdata", rdata, 32'hDEADBEEF);
        tick();
        check("t1_dfb_once", 32'(data_feedback), 32'h0);
        // 2: halfword write to the write buffer
        request(2'b10, 20'd3, 2'b01, 1'b1, 32'h0000A5C3);
        tick();
        request(2'b00, 20'd0, 2'b10, 1'b0, 32'h0);
        check("t2_haddr", HADDR, 32'h0010_0006);
        check("t2_hwrite", 32'(HWRITE), 32'h1);
        check("t2_hsize", 32'(HSIZE), 32'h1);
        check("t2_htrans", 32'(HTRANS), 32'h2);
        tick();
        check("t2_hwdata", HWDATA, 32'hA5C3A5C3);
        tick();
        check("t2_dfb", 32'(data_feedback), 32'h1);
        check("t2_rdata_kept", rdata, 32'hDEADBEEF);
        tick();
        check("t2_dfb_once", 32'(data_feedback), 32'h0);
        // 3: wait states, 2 in ADDR and 3 in DATA
        request(2'b01, 20'd2, 2'b10, 1'b0, 32'h0);
        HREADY = 1'b0;
        HRDATA = 32'h12345678;
        tick();
        request(2'b01, 20'd9, 2'b01, 1'b1, 32'h0);
        tick();
        check("t3_hold_htrans1", 32'(HTRANS), 32'h2);
        check("t3_hold_haddr1", HADDR, 32'h8);
        tick();
        check("t3_hold_htrans2", 32'(HTRANS), 32'h2);
        check("t3_hold_haddr2", HADDR, 32'h8);
        check("t3_hold_hsize", 32'(HSIZE), 32'h2);
        HREADY = 1'b1;
        tick();
        HREADY = 1'b0;
        check("t3_data_htrans", 32'(HTRANS), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_dfb_wait", 32'(data_feedback), 32'h0);
        end
        HREADY = 1'b1;
        mode = 2'b00;
        tick();
        check("t3_dfb", 32'(data_feedback), 32'h1);
        check("t3_rdata", rdata, 32'h12345678);
        tick();
        check("t3_dfb_once", 32'(data_feedback), 32'h0);
        // halfword read of the upper lane
        request(2'b01, 20'd1, 2'b01, 1'b0, 32'h0);
        HRDATA = 32'hCAFEBABE;
        tick();
        mode = 2'b00;
        check("hr_haddr", HADDR, 32'h2);
        tick();
        tick();
        check("hr_dfb", 32'(data_feedback), 32'h1);
        check("hr_rdata", rdata, 32'h0000CAFE);
        // reserved mode issues nothing
        mode = 2'b11;
        tick();
        check("m11_htrans1", 32'(HTRANS), 32'h0);
        tick();
        check("m11_htrans2", 32'(HTRANS), 32'h0);
        check("m11_dfb", 32'(data_feedback), 32'h0);
        // 4: error response
        request(2'b01, 20'd0, 2'b10, 1'b0, 32'h0);
        tick();
        request(2'b10, 20'd0, 2'b10, 1'b0, 32'h0);
        tick();
        HREADY = 1'b0;
        HRESP = 1'b1;
        tick();
        check("t4_err_state_htrans", 32'(HTRANS), 32'h0);
        check("t4_err_not_yet", 32'(bus_err), 32'h0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        mode = 2'b00;
        check("t4_bus_err", 32'(bus_err), 32'h1);
        check("t4_no_dfb", 32'(data_feedback), 32'h0);
        check("t4_rdata_kept", rdata, 32'h0000CAFE);
        tick();
        check("t4_err_cleared", 32'(bus_err), 32'h0);
        check("t4_no_dfb2", 32'(data_feedback), 32'h0);
        // 5: reset in the data phase
        request(2'b10, 20'd4, 2'b10, 1'b0, 32'h11112222);
        tick();
        mode = 2'b00;
        tick();
        rst = 1'b1;
        #1;
        check("t5_htrans", 32'(HTRANS), 32'h0);
        check("t5_haddr", HADDR, 32'h0);
        check("t5_hwdata", HWDATA, 32'h0);
        check("t5_hwrite", 32'(HWRITE), 32'h0);
        check("t5_hsize", 32'(HSIZE), 32'h2);
        check("t5_rdata", rdata, 32'h0);
        check("t5_dfb", 32'(data_feedback), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_no_dfb1", 32'(data_feedback), 32'h0);
        tick();
        check("t5_no_dfb2", 32'(data_feedback), 32'h0);
        check("t5_idle", 32'(HTRANS), 32'h0);
        // 6: pixel index at the buffer limit
        request(2'b01, 20'd307200, 2'b10, 1'b0, 32'h0);
        HRDATA = 32'h0BADF00D;
        tick();
`ifdef AHB_BOUNDS_CHECK_EN
        check("t6_no_transfer", 32'(HTRANS), 32'h0);
        check("t6_bus_err", 32'(bus_err), 32'h1);
        mode = 2'b00;
        tick();
        check("t6_no_dfb", 32'(data_feedback), 32'h0);
        check("t6_err_cleared", 32'(bus_err), 32'h0);
`else
        mode = 2'b00;
        check("t6_transfer", 32'(HTRANS), 32'h2);
        check("t6_haddr", HADDR, 32'h0012_C000);
        tick();
        tick();
        check("t6_dfb", 32'(data_feedback), 32'h1);
        check("t6_rdata", rdata, 32'h0BADF00D);
        check("t6_no_err", 32'(bus_err), 32'h0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
